// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank access arbiter: data/select widths,
// register select codes and the arbiter FSM state encoding.
package regbank_pkg;

  localparam int DATA_W = 8;
  localparam int RS_W   = 2;

  localparam logic [RS_W-1:0] S0 = 2'b00;
  localparam logic [RS_W-1:0] S1 = 2'b01;
  localparam logic [RS_W-1:0] T0 = 2'b10;
  localparam logic [RS_W-1:0] T1 = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    READBACK = 2'b10,
    DONE     = 2'b11
  } arbStateT;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: prio names the port that wins a tie (0 or 1).
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = prio;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates two requesters onto one register bank; each transaction runs
// ACCESS -> READBACK -> DONE and returns the post-access register value.
module reg_access_arbiter
  import regbank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [RS_W-1:0]   rs0,
  input  logic [RS_W-1:0]   rs1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              bank_wr,
  output logic [RS_W-1:0]   bank_rs,
  output logic [DATA_W-1:0] bank_data,
  input  logic [DATA_W-1:0] bank_val
);

  arbStateT          state;
  arbStateT          nextState;
  logic              prio;
  logic              owner;
  logic              pickWinner;
  logic              pickValid;
  logic              latWe;
  logic [RS_W-1:0]   latRs;
  logic [DATA_W-1:0] latData;
  logic              grantNow;

  rr_pick2 uPick (
    .req0   (req0),
    .req1   (req1),
    .prio   (prio),
    .winner (pickWinner),
    .valid  (pickValid)
  );

  assign grantNow = (state == IDLE) && pickValid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
      rdata <= '0;
    end else begin
      state <= nextState;
      if (grantNow) begin
        owner <= pickWinner;
      end
      // Priority moves to the port that was not just served.
      if (state == DONE) begin
        prio <= ~owner;
      end
      if (state == READBACK) begin
        rdata <= bank_val;
      end
    end
  end

  // Request fields are captured once at grant; later changes are ignored.
  always_ff @(posedge clk) begin
    if (grantNow) begin
      latWe   <= pickWinner ? we1    : we0;
      latRs   <= pickWinner ? rs1    : rs0;
      latData <= pickWinner ? wdata1 : wdata0;
    end
  end

  always_comb begin
    nextState = state;
    bank_wr   = 1'b0;
    bank_rs   = '0;
    bank_data = '0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    busy      = (state != IDLE);
    if (state != IDLE) begin
      gnt0 = ~owner;
      gnt1 = owner;
    end
    case (state)
      IDLE: begin
        if (pickValid) begin
          nextState = ACCESS;
        end
      end
      ACCESS: begin
        bank_wr   = latWe;
        bank_rs   = latRs;
        bank_data = latData;
        nextState = READBACK;
      end
      READBACK: begin
        bank_rs   = latRs;
        nextState = DONE;
      end
      DONE: begin
        done0     = ~owner;
        done1     = owner;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a small behavioural register bank.
module tb_reg_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [1:0] rs0, rs1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1, busy, bank_wr;
  logic [7:0] rdata, bank_data, bank_val;
  logic [1:0] bank_rs;

  logic [7:0] bank [4] = '{default: 8'h00};
  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  int doneAt0, doneAt1;
  int lastPort;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bank_wr) bank[bank_rs] <= bank_data;
  end
  assign bank_val = bank[bank_rs];

  reg_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .rs0(rs0), .rs1(rs1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .bank_wr(bank_wr),
    .bank_rs(bank_rs), .bank_data(bank_data), .bank_val(bank_val)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle that samples the request; returns in DONE.
  task automatic txn(input int port, input logic wr, input logic [1:0] rs,
                     input logic [7:0] wd, input logic [7:0] expR,
                     input bit dropInRb, input string tag, output int doneCyc);
    logic [1:0] oneHot;
    oneHot = (port == 1) ? 2'b10 : 2'b01;
    step();
    chk({tag, ".acc.gnt"},  {gnt1, gnt0}, oneHot);
    chk({tag, ".acc.bank"}, {busy, bank_wr, bank_rs, bank_data}, {1'b1, wr, rs, wd});
    chk({tag, ".acc.done"}, {done1, done0}, 2'b00);
    step();
    chk({tag, ".rb.bank"},  {gnt1, gnt0, bank_wr, bank_rs}, {oneHot, 1'b0, rs});
    if (dropInRb) begin
      if (port == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    step();
    chk({tag, ".done"},     {gnt1, gnt0, done1, done0, bank_wr}, {oneHot, oneHot, 1'b0});
    chk({tag, ".rdata"},    rdata, expR);
    doneCyc = cyc;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    rs0 = 0; rs1 = 0; wdata0 = 0; wdata1 = 0;
    step(2);
    chk("reset.outs", {gnt0, gnt1, done0, done1, busy, bank_wr, bank_rs, bank_data}, 0);
    chk("reset.rdata", rdata, 8'h00);
    rst_n = 1'b1;

    // Single write from port 0 to t0.
    req0 = 1; we0 = 1; rs0 = 2'b10; wdata0 = 8'h5A;
    txn(0, 1'b1, 2'b10, 8'h5A, 8'h5A, 1'b0, "single", doneAt0);
    req0 = 0;
    step();
    chk("single.idle", {gnt0, gnt1, done0, done1, busy, bank_wr, bank_rs, bank_data}, 0);
    chk("single.hold", rdata, 8'h5A);
    step();
    chk("single.hold2", rdata, 8'h5A);

    // Contention straight after reset: port 0 first, then port 1.
    doReset();
    chk("cont.rstRdata", rdata, 8'h00);
    req0 = 1; we0 = 1; rs0 = 2'b00; wdata0 = 8'h11;
    req1 = 1; we1 = 1; rs1 = 2'b11; wdata1 = 8'h22;
    txn(0, 1'b1, 2'b00, 8'h11, 8'h11, 1'b0, "cont0", doneAt0);
    req0 = 0;
    step();
    chk("cont.idle", busy, 1'b0);
    txn(1, 1'b1, 2'b11, 8'h22, 8'h22, 1'b0, "cont1", doneAt1);
    chk("cont.gap", doneAt1 - doneAt0, 4);
    req1 = 0;
    step();

    // Fairness: both ports request continuously.
    doReset();
    req0 = 1; we0 = 1; rs0 = 2'b00; wdata0 = 8'h33;
    req1 = 1; we1 = 0; rs1 = 2'b00; wdata1 = 8'h00;
    lastPort = -1;
    for (int i = 0; i < 8; i++) begin
      int p;
      int dc;
      p = i % 2;
      if (p == 0) txn(0, 1'b1, 2'b00, 8'h33, 8'h33, 1'b0, "fair0", dc);
      else        txn(1, 1'b0, 2'b00, 8'h00, 8'h33, 1'b0, "fair1", dc);
      chk("fair.alt", (gnt1 ? 1 : 0) != lastPort, 1);
      lastPort = gnt1 ? 1 : 0;
      if (i == 7) begin req0 = 0; req1 = 0; end
      step();
    end
    chk("fair.endIdle", busy, 1'b0);

    // Read after write: port 1 writes s1, port 0 reads it back.
    req1 = 1; we1 = 1; rs1 = 2'b01; wdata1 = 8'hC3;
    txn(1, 1'b1, 2'b01, 8'hC3, 8'hC3, 1'b0, "raw.wr", doneAt1);
    req1 = 0;
    req0 = 1; we0 = 0; rs0 = 2'b01; wdata0 = 8'h00;
    step();
    txn(0, 1'b0, 2'b01, 8'h00, 8'hC3, 1'b0, "raw.rd", doneAt0);
    req0 = 0;
    step();

    // Reset during ACCESS of a write discards the transaction.
    req0 = 1; we0 = 1; rs0 = 2'b11; wdata0 = 8'h77;
    step();
    chk("abort.acc", {gnt0, bank_wr, bank_rs}, {1'b1, 1'b1, 2'b11});
    rst_n = 0; req0 = 0;
    step();
    chk("abort.outs", {gnt0, gnt1, done0, done1, busy, bank_wr, bank_rs, bank_data}, 0);
    chk("abort.rdata", rdata, 8'h00);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort.quiet", {done0, done1, bank_wr, busy}, 4'b0000);
    end

    // Request dropped in READBACK still completes once.
    req1 = 1; we1 = 0; rs1 = 2'b01; wdata1 = 8'h00;
    txn(1, 1'b0, 2'b01, 8'h00, 8'hC3, 1'b1, "drop", doneAt1);
    step();
    chk("drop.idle", {busy, done1, gnt1}, 3'b000);
    step();
    chk("drop.noGrant", {busy, gnt0, gnt1, bank_wr}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, listed first: clk (rising edge) and rst_n (synchronous, active-low).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 req0 / req1  input  1  access request from port 0 (execute unit) / port 1 (load unit).
REQ-005 we0 / we1  input  1  request is a write (1) or a read (0).
REQ-006 rs0 / rs1  input  2  target register: 00=s0, 01=s1, 10=t0, 11=t1.
REQ-007 wdata0 / wdata1  input  8  write data.
REQ-008 gnt0 / gnt1  output  1  port owns the bank, high from ACCESS through DONE.
REQ-009 done0 / done1  output  1  one-cycle completion pulse.
REQ-010 rdata  output  8  registered value of the target register after the access; valid while done0 or done1 is high.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 bank_wr  output  1  register-bank write enable.
REQ-013 bank_rs  output  2  register-bank select.
REQ-014 bank_data  output  8  register-bank write data.
REQ-015 bank_val  input  8  register-bank read value (combinational from bank_rs).

Function
REQ-016 The FSM SHALL have four states: IDLE, ACCESS, READBACK, DONE.
REQ-017 IDLE: with no req, stay in IDLE; with any req, latch the winner's we/rs/wdata and go to ACCESS.
REQ-018 Arbitration SHALL be two-way round-robin: with both req high, the port holding priority wins; with one req high, that port wins regardless of priority.
REQ-019 After each completed transaction, priority SHALL pass to the port not served.
REQ-020 ACCESS (1 cycle): bank_rs = latched rs, bank_data = latched wdata, bank_wr = latched we; next state READBACK.
REQ-021 READBACK (1 cycle): bank_wr = 0, bank_rs = latched rs, capture bank_val into rdata at the cycle end; next state DONE.
REQ-022 DONE (1 cycle): assert done of the granted port only; next state IDLE unconditionally.
REQ-023 Latency SHALL be fixed: req sampled in IDLE at cycle N gives done at cycle N+3; peak throughput is one transaction per 4 cycles.
REQ-024 The requester SHALL hold req and its fields until done; the arbiter uses only the values latched at grant.
REQ-025 A req dropped mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.
REQ-026 A req still high in DONE SHALL be re-arbitrated in the next IDLE cycle as a new transaction.
REQ-027 bank_wr SHALL be high only in ACCESS and only for writes; it is never high for two consecutive cycles.
REQ-028 In IDLE, bank_rs, bank_data and bank_wr SHALL be 0, and rdata SHALL hold its last value.
REQ-029 gnt0 and gnt1 SHALL be mutually exclusive, as SHALL done0 and done1.

Reset
REQ-030 With rst_n low at a clock edge, the block SHALL set state=IDLE, priority=port 0, rdata=0, and all gnt/done/busy/bank outputs to 0.
REQ-031 A reset during ACCESS SHALL prevent any write on the next cycle; the in-flight transaction is discarded with no done pulse.

Structure
REQ-032 Shared package regbank_pkg SHALL hold the FSM state encoding, register select constants (S0, S1, T0, T1), DATA_W=8 and RS_W=2.
REQ-033 The round-robin decision SHALL be a sub-module rr_pick2 (inputs req0, req1, prio; outputs winner and valid), purely combinational.

Verification
REQ-034 Single write: req0, we0=1, rs0=10, wdata0=0x5A in IDLE -> bank_wr high for exactly 1 cycle with bank_rs=10 and bank_data=0x5A; done0 at N+3 with rdata=0x5A.
REQ-035 Contention after reset: req0 and req1 both asserted together -> port 0 is served first and port 1 second; done1 arrives 4 cycles after done0.
REQ-036 Fairness: both ports requesting continuously for 8 transactions -> grants alternate 0,1,0,1 with no port served twice in a row.
REQ-037 Read after write: port 1 writes 0xC3 to s1, then port 0 reads s1 -> rdata=0xC3 at done0 and bank_wr=0 during the read.
REQ-038 Abort: rst_n low during ACCESS of a write -> no bank_wr pulse afterwards, no done, and the block is in IDLE with all outputs 0 in the following cycle.
REQ-039 Dropped request: req1 deasserted in READBACK -> done1 still pulses once, and the next IDLE grants no transaction.
